// File: rtl/vga_rx_monitor_pkg.sv
// Shared 640x480 timing constants, receiver state encoding and the pixel signature step.
// Also used by the VGA controller so both ends agree on the format.
package vga_rx_monitor_pkg;

   typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} rxState_t;

   localparam int H_ACTIVE = 640;
   localparam int H_FRONT  = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BACK   = 48;
   localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_ACTIVE = 480;
   localparam int V_FRONT  = 10;
   localparam int V_SYNC   = 2;
   localparam int V_BACK   = 33;
   localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   // Rotate left by one, then fold in the new pixel.
   function automatic logic [23:0] sigStep(input logic [23:0] sig, input logic [23:0] rgb);
      return {sig[22:0], sig[23]} ^ rgb;
   endfunction

endpackage

// File: rtl/vga_rx_monitor_if.sv
// Video bundle tapped from the VGA output registers: pixel strobe, syncs, blanking and colour.
interface vga_rx_monitor_if;
   logic        pix_en;
   logic        hs;
   logic        vs;
   logic        blank_n;
   logic [23:0] rgb;

   modport master (output pix_en, hs, vs, blank_n, rgb);
   modport slave  (input  pix_en, hs, vs, blank_n, rgb);
endinterface

// File: rtl/vga_rx_monitor_edge.sv
// pix_en-qualified sampling of the video bundle; flags sync assertions against the previous sample.
module vga_edge_sampler #(
   parameter bit SYNC_POL = 1'b0
) (
   input  logic            CLOCK_50,
   input  logic            reset,
   vga_rx_monitor_if.slave vid,
   output logic            smpStb,
   output logic            hsAssert,
   output logic            vsAssert,
   output logic            smpActive,
   output logic [23:0]     smpRgb
);
   logic hsPrev;
   logic vsPrev;

   // Previous levels start deasserted so a sync held asserted through reset still counts.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         hsPrev <= ~SYNC_POL;
         vsPrev <= ~SYNC_POL;
      end else if (vid.pix_en) begin
         hsPrev <= vid.hs;
         vsPrev <= vid.vs;
      end
   end

   assign smpStb    = vid.pix_en;
   assign hsAssert  = vid.pix_en && (vid.hs == SYNC_POL) && (hsPrev != SYNC_POL);
   assign vsAssert  = vid.pix_en && (vid.vs == SYNC_POL) && (vsPrev != SYNC_POL);
   assign smpActive = vid.pix_en && vid.blank_n;
   assign smpRgb    = vid.rgb;
endmodule

// File: rtl/vga_rx_monitor.sv
// Receive-side VGA monitor: recovers pixel coordinates, measures line/frame timing,
// checks it against the expected format and produces a per-frame pixel signature.
//   state  | meaning
//   SEARCH | no VS seen since reset, frame boundaries unknown
//   ALIGN  | framed, last closed frame was bad or none closed yet
//   LOCKED | last closed frame matched the format
module vga_rx_monitor #(
   parameter int H_ACTIVE = vga_rx_monitor_pkg::H_ACTIVE,
   parameter int V_ACTIVE = vga_rx_monitor_pkg::V_ACTIVE,
   parameter int H_TOTAL  = vga_rx_monitor_pkg::H_TOTAL,
   parameter int V_TOTAL  = vga_rx_monitor_pkg::V_TOTAL,
   parameter bit SYNC_POL = 1'b0,
   parameter int CW       = 10
) (
   input  logic            CLOCK_50,
   input  logic            reset,
   vga_rx_monitor_if.slave vid,
   output logic            pix_valid,
   output logic [CW-1:0]   pix_x,
   output logic [CW-1:0]   pix_y,
   output logic [23:0]     pix_rgb,
   output logic [CW-1:0]   line_len,
   output logic [CW-1:0]   frame_lines,
   output logic [23:0]     frame_sig,
   output logic            frame_done,
   output logic            fmt_err,
   output logic            locked
);
   import vga_rx_monitor_pkg::*;

   localparam logic [18:0] ACT_FRAME = 19'(H_ACTIVE * V_ACTIVE);

   function automatic logic [CW-1:0] satInc(input logic [CW-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic          smpStb, hsA, vsA, act;
   logic [23:0]   smpRgb;
   logic [CW-1:0] hCnt, xCnt, yCnt, vCnt;
   logic [CW-1:0] lenNow, linesNow;
   logic          lineHasAct, badLine, badNow, frameGood;
   logic [18:0]   actCnt;
   logic [23:0]   sig;
   rxState_t      state, stateNext;

   vga_edge_sampler #(.SYNC_POL(SYNC_POL)) u_sampler (
      .CLOCK_50  (CLOCK_50),
      .reset     (reset),
      .vid       (vid),
      .smpStb    (smpStb),
      .hsAssert  (hsA),
      .vsAssert  (vsA),
      .smpActive (act),
      .smpRgb    (smpRgb)
   );

   // A line closing on the VS sample is folded into the frame it ends.
   always_comb begin
      lenNow    = satInc(hCnt);
      linesNow  = hsA ? satInc(vCnt) : vCnt;
      badNow    = badLine || (hsA && (lenNow != CW'(H_TOTAL)));
      frameGood = (linesNow == CW'(V_TOTAL)) && !badNow && (actCnt == ACT_FRAME);
      stateNext = state;
      if (vsA) begin
         case (state)
            SEARCH:  stateNext = ALIGN;
            ALIGN:   if (frameGood) stateNext = LOCKED;
            LOCKED:  if (!frameGood) stateNext = ALIGN;
            default: stateNext = SEARCH;
         endcase
      end
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) state <= SEARCH;
      else       state <= stateNext;
   end

   assign locked = (state == LOCKED);

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         pix_valid   <= 1'b0;
         pix_x       <= '0;
         pix_y       <= '0;
         pix_rgb     <= '0;
         line_len    <= '0;
         frame_lines <= '0;
         frame_sig   <= '0;
         frame_done  <= 1'b0;
         fmt_err     <= 1'b0;
         hCnt        <= '0;
         xCnt        <= '0;
         yCnt        <= '0;
         vCnt        <= '0;
         lineHasAct  <= 1'b0;
         badLine     <= 1'b0;
         actCnt      <= '0;
         sig         <= '0;
      end else begin
         pix_valid  <= 1'b0;
         frame_done <= 1'b0;
         fmt_err    <= 1'b0;
         if (smpStb) begin
            hCnt <= satInc(hCnt);
            if (act) begin
               pix_valid  <= 1'b1;
               pix_x      <= xCnt;
               pix_y      <= yCnt;
               pix_rgb    <= smpRgb;
               xCnt       <= satInc(xCnt);
               lineHasAct <= 1'b1;
               actCnt     <= (&actCnt) ? actCnt : actCnt + 1'b1;
               sig        <= sigStep(sig, smpRgb);
            end
            if (hsA) begin
               line_len   <= lenNow;
               hCnt       <= '0;
               xCnt       <= '0;
               vCnt       <= linesNow;
               badLine    <= badNow;
               lineHasAct <= act;
               if (lineHasAct) yCnt <= satInc(yCnt);
            end
            if (vsA) begin
               frame_lines <= linesNow;
               frame_sig   <= sig;
               vCnt        <= '0;
               yCnt        <= '0;
               badLine     <= 1'b0;
               actCnt      <= '0;
               sig         <= '0;
               if (state != SEARCH) begin
                  frame_done <= 1'b1;
                  fmt_err    <= !frameGood;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench for vga_rx_monitor on a shrunken 12x7-sample format (8x4 active).
module tb_vga_rx_monitor;
   localparam int HT = 12, HA = 8, HOFF = 3, HSYNC = 2;
   localparam int VT = 7,  VA = 4, VOFF = 2, VSYNC = 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   vga_rx_monitor_if vif();

   logic        pixValid, frameDone, fmtErr, locked;
   logic [9:0]  pixX, pixY, lineLen, frameLines;
   logic [23:0] pixRgb, frameSig;

   vga_rx_monitor #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT), .V_TOTAL(VT)) dut (
      .CLOCK_50    (clk),
      .reset       (rst),
      .vid         (vif),
      .pix_valid   (pixValid),
      .pix_x       (pixX),
      .pix_y       (pixY),
      .pix_rgb     (pixRgb),
      .line_len    (lineLen),
      .frame_lines (frameLines),
      .frame_sig   (frameSig),
      .frame_done  (frameDone),
      .fmt_err     (fmtErr),
      .locked      (locked)
   );

   int checks = 0, errors = 0;
   int validCnt = 0, doneCnt = 0, errCnt = 0, mark = 0;
   logic [9:0]  capX = '0, capY = '0;
   logic [23:0] capRgb = '0;
   logic        lockAtDone = 1'b0;
   logic [23:0] modelSig = '0, lastSig = '0;

   always @(negedge clk) begin
      if (pixValid) begin
         if (validCnt == mark) begin
            capX   = pixX;
            capY   = pixY;
            capRgb = pixRgb;
         end
         validCnt++;
      end
      if (frameDone) begin
         doneCnt++;
         lockAtDone = locked;
      end
      if (fmtErr) errCnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] pixVal(input int kind, input int x, input int y);
      case (kind)
         0:       return 24'h0;
         1:       return (x == 0 && y == 0) ? 24'h000001 : 24'h0;
         default: return {8'(x * 37 + 5), 8'(y * 91 + 3), 8'(x * y + x)};
      endcase
   endfunction

   // One pixel sample, then an idle CLOCK_50 cycle carrying junk the DUT must ignore.
   task automatic drive_sample(input logic h, input logic v, input logic b, input logic [23:0] c);
      @(negedge clk);
      vif.pix_en  = 1'b1;
      vif.hs      = h;
      vif.vs      = v;
      vif.blank_n = b;
      vif.rgb     = c;
      if (b) modelSig = {modelSig[22:0], modelSig[23]} ^ c;
      @(negedge clk);
      vif.pix_en  = 1'b0;
      vif.hs      = 1'($urandom_range(0, 1));
      vif.vs      = 1'($urandom_range(0, 1));
      vif.blank_n = 1'($urandom_range(0, 1));
      vif.rgb     = 24'($urandom);
      #1;
   endtask

   task automatic drive_line(input int l, input int s0, input int s1, input int vsOff, input int kind);
      int   idx;
      logic h, v, b;
      for (int s = s0; s < s1; s++) begin
         idx = l * HT + s;
         h   = !(s < HSYNC);
         v   = !(idx >= vsOff && idx < vsOff + VSYNC * HT);
         b   = (l >= VOFF && l < VOFF + VA && s >= HOFF && s < HOFF + HA);
         if (idx == vsOff) begin
            lastSig  = modelSig;
            modelSig = '0;
         end
         drive_sample(h, v, b, b ? pixVal(kind, s - HOFF, l - VOFF) : 24'h0);
      end
   endtask

   task automatic run_frame(input int kind, input int vsOff);
      for (int l = 0; l < VT; l++) drive_line(l, 0, HT, vsOff, kind);
   endtask

   int d0;

   initial begin
      vif.pix_en = 1'b0; vif.hs = 1'b1; vif.vs = 1'b1; vif.blank_n = 1'b0; vif.rgb = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk); #1;
      chk("rst_flags", 32'({pixValid, frameDone, fmtErr, locked}), 0);
      chk("rst_xy", 32'({pixX, pixY}), 0);
      chk("rst_rgb", 32'(pixRgb), 0);
      chk("rst_len_lines", 32'({lineLen, frameLines}), 0);
      chk("rst_sig", 32'(frameSig), 0);

      // No sync at all: h_cnt must saturate, not wrap.
      repeat (2000) drive_sample(1'b1, 1'b1, 1'b0, 24'h0);
      chk("nosync_locked", 32'(locked), 0);
      chk("nosync_done", doneCnt, 0);
      chk("nosync_line_len", 32'(lineLen), 0);
      drive_sample(1'b0, 1'b1, 1'b0, 24'h0);
      chk("sat_line_len", 32'(lineLen), 1023);
      drive_sample(1'b1, 1'b1, 1'b0, 24'h0);

      // Nominal frames: first VS only aligns, second close locks.
      run_frame(0, 3);
      chk("first_vs_no_done", doneCnt, 0);
      chk("align_not_locked", 32'(locked), 0);
      mark = validCnt;
      run_frame(0, 3);
      chk("done_after_close", doneCnt, 1);
      chk("lock_with_done", 32'(lockAtDone), 1);
      chk("locked_nominal", 32'(locked), 1);
      chk("line_len_nom", 32'(lineLen), HT);
      chk("frame_lines_nom", 32'(frameLines), VT);
      chk("sig_zero", 32'(frameSig), 0);
      chk("valid_per_frame", validCnt - mark, HA * VA);

      mark = validCnt;
      run_frame(1, 3);
      chk("first_pix_xy", 32'({capX, capY}), 0);
      chk("first_pix_rgb", 32'(capRgb), 1);
      chk("valid_per_frame2", validCnt - mark, HA * VA);
      run_frame(2, 3);
      chk("sig_single_pixel", 32'(frameSig), 32'h000080);
      run_frame(0, 3);
      chk("sig_pattern", 32'(frameSig), 32'(lastSig));
      chk("done_count", doneCnt, 4);
      chk("no_fmt_err", errCnt, 0);

      // Line 3 shortened by one sample.
      for (int l = 0; l < 5; l++) drive_line(l, 0, (l == 3) ? HT - 1 : HT, 3, 0);
      chk("short_line_len", 32'(lineLen), HT - 1);
      drive_line(5, 0, HT, 3, 0);
      drive_line(6, 0, HT, 3, 0);
      run_frame(0, 3);
      chk("short_fmt_err", errCnt, 1);
      chk("short_done", doneCnt, 6);
      chk("short_unlocked", 32'(locked), 0);
      chk("short_lockatdone", 32'(lockAtDone), 0);
      run_frame(0, 3);
      chk("relock", 32'(locked), 1);
      chk("relock_no_err", errCnt, 1);

      // VS coincident with HS.
      mark = validCnt;
      run_frame(1, 0);
      chk("coinc_lines", 32'(frameLines), VT);
      chk("coinc_first_xy", 32'({capX, capY}), 0);
      chk("coinc_first_rgb", 32'(capRgb), 1);
      run_frame(0, 0);
      chk("coinc_lines2", 32'(frameLines), VT);
      chk("coinc_sig", 32'(frameSig), 32'h000080);
      chk("coinc_locked", 32'(locked), 1);
      chk("coinc_no_err", errCnt, 1);

      // Reset mid-frame, right after an active pixel.
      for (int l = 0; l < 3; l++) drive_line(l, 0, HT, 3, 0);
      drive_line(3, 0, 6, 3, 0);
      chk("pre_rst_valid", 32'({pixValid, locked}), 3);
      #1 rst = 1'b1;
      #1;
      chk("rst_mid_flags", 32'({pixValid, frameDone, fmtErr, locked}), 0);
      chk("rst_mid_xy", 32'({pixX, pixY}), 0);
      chk("rst_mid_len", 32'({lineLen, frameLines}), 0);
      chk("rst_mid_sig", 32'(frameSig), 0);
      @(negedge clk);
      rst = 1'b0;
      drive_line(3, 6, HT, 3, 0);
      for (int l = 4; l < VT; l++) drive_line(l, 0, HT, 3, 0);
      d0 = doneCnt;
      run_frame(0, 3);
      chk("post_rst_first_vs", doneCnt - d0, 0);
      chk("post_rst_unlocked", 32'(locked), 0);
      run_frame(0, 3);
      chk("post_rst_done", doneCnt - d0, 1);
      chk("post_rst_relock", 32'(locked), 1);
      chk("post_rst_no_err", errCnt, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
